// File: rtl/irq_conditioner.sv
// irq_conditioner: front end for raw external interrupt lines, feeding the core's IRQ inputs.
// Each line passes through these stages:
//   - 2-FF synchroniser
//   - debounce filter
//   - selectable edge detector
//   - pending latch
//   - enable mask
// Firmware reads and clears status through a four-word register window on the native CPU bus.
//
// Ports:
//   clk, resetn      system clock, synchronous active-low reset
//   irq_in           raw asynchronous interrupt pins
//   sel              register window selected by the address decoder
//   mem_valid        bus request valid
//   mem_addr         byte address in window (word index = [3:2])
//   mem_wstrb        write strobes; all zero means read
//   mem_wdata        write data
//   mem_rdata        read data, valid while mem_ready, else 0
//   mem_ready        one-cycle transfer-complete pulse
//   irq_out          registered, masked interrupt requests
//
// Register map (word index):
//   0 ENABLE    rw
//   1 PENDING   read, write-1-to-clear
//   2 LEVEL     ro
//   3 EDGE_SEL  rw, 1 = falling
module irq_conditioner #(
    parameter int unsigned N_IRQ    = 3,
    parameter int unsigned DEBOUNCE = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             sel,
    input  logic             mem_valid,
    input  logic [3:0]       mem_addr,
    input  logic [3:0]       mem_wstrb,
    input  logic [31:0]      mem_wdata,
    output logic [31:0]      mem_rdata,
    output logic             mem_ready,
    output logic [N_IRQ-1:0] irq_out
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE - 1);

    localparam logic [1:0] AddrEnable  = 2'd0;
    localparam logic [1:0] AddrPending = 2'd1;
    localparam logic [1:0] AddrLevel   = 2'd2;
    localparam logic [1:0] AddrEdgeSel = 2'd3;

    logic [N_IRQ-1:0] s1_q, s1_d;
    logic [N_IRQ-1:0] s2_q, s2_d;
    logic [N_IRQ-1:0] stable_q, stable_d;
    logic [N_IRQ-1:0] stable_dly_q, stable_dly_d;
    logic [CNT_W-1:0] cnt_q [N_IRQ];
    logic [CNT_W-1:0] cnt_d [N_IRQ];
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] enable_q, enable_d;
    logic [N_IRQ-1:0] edge_sel_q, edge_sel_d;
    logic [N_IRQ-1:0] irq_out_q, irq_out_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             ready_q, ready_d;

    logic [N_IRQ-1:0] edge_det;
    logic [N_IRQ-1:0] pend_clr;
    logic [31:0]      rd_word;
    logic [1:0]       word;
    logic             accept;
    logic             is_write;
    logic             wr_en;

    // Address byte offset and upper data bits are architecturally ignored.
    logic unused_bits;
    assign unused_bits = ^{mem_wdata[31:N_IRQ], mem_addr[1:0]};

    // Synchroniser and debounce: a level change is accepted only after s2 has
    // disagreed with the stable level for DEBOUNCE consecutive cycles.
    always_comb begin
        s1_d     = irq_in;
        s2_d     = s1_q;
        stable_d = stable_q;
        for (int i = 0; i < N_IRQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                stable_d[i] = s2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    assign stable_dly_d = stable_q;
    assign edge_det     = (stable_q & ~stable_dly_q & ~edge_sel_q) |
                          (~stable_q & stable_dly_q & edge_sel_q);

    // Bus decode; mem_ready low between transfers blocks back-to-back acceptance.
    assign word     = mem_addr[3:2];
    assign accept   = sel & mem_valid & ~ready_q;
    assign is_write = |mem_wstrb;
    assign wr_en    = accept & is_write & mem_wstrb[0];

    always_comb begin
        rd_word = '0;
        unique case (word)
            AddrEnable:  rd_word[N_IRQ-1:0] = enable_q;
            AddrPending: rd_word[N_IRQ-1:0] = pending_q;
            AddrLevel:   rd_word[N_IRQ-1:0] = stable_q;
            AddrEdgeSel: rd_word[N_IRQ-1:0] = edge_sel_q;
        endcase
    end

    always_comb begin
        enable_d   = enable_q;
        edge_sel_d = edge_sel_q;
        pend_clr   = '0;
        if (wr_en) begin
            unique case (word)
                AddrEnable:  enable_d   = mem_wdata[N_IRQ-1:0];
                AddrPending: pend_clr   = mem_wdata[N_IRQ-1:0];
                AddrLevel:   ;
                AddrEdgeSel: edge_sel_d = mem_wdata[N_IRQ-1:0];
            endcase
        end
        // A new edge in the same cycle as a clear keeps the line pending.
        pending_d = (pending_q & ~pend_clr) | edge_det;
        irq_out_d = pending_q & enable_q;
        ready_d   = accept;
        rdata_d   = (accept && !is_write) ? rd_word : '0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_q         <= '0;
            s2_q         <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            for (int i = 0; i < N_IRQ; i++) begin
                cnt_q[i] <= '0;
            end
            pending_q    <= '0;
            enable_q     <= '0;
            edge_sel_q   <= '0;
            irq_out_q    <= '0;
            rdata_q      <= '0;
            ready_q      <= 1'b0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            for (int i = 0; i < N_IRQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            pending_q    <= pending_d;
            enable_q     <= enable_d;
            edge_sel_q   <= edge_sel_d;
            irq_out_q    <= irq_out_d;
            rdata_q      <= rdata_d;
            ready_q      <= ready_d;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;
    assign irq_out   = irq_out_q;

endmodule

// File: tb/tb_irq_conditioner.sv
// Self-checking bench for irq_conditioner with DEBOUNCE=4, N_IRQ=3.
// Directed tests use hand-derived constants.
// The random phase is compared against a window-based reference model.
module tb_irq_conditioner;

    localparam int N = 3;
    localparam int D = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic [N-1:0]  irq_in;
    logic          sel;
    logic          mem_valid;
    logic [3:0]    mem_addr;
    logic [3:0]    mem_wstrb;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          mem_ready;
    logic [N-1:0]  irq_out;

    irq_conditioner #(
        .N_IRQ    (N),
        .DEBOUNCE (D),
        .CNT_W    (4)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .irq_in    (irq_in),
        .sel       (sel),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wstrb (mem_wstrb),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .irq_out   (irq_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    // stable_m is the accepted level.
    // hist holds the most recent D synchronised samples per line.
    logic [N-1:0] s1_m, s2_m, stable_m, stable_prev_m;
    logic [N-1:0] pend_m, en_m, esel_m, irq_m;
    logic [31:0]  rdata_m;
    logic         ready_m, rd_m;
    bit           hist [N][D];
    int           fill [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs about to be sampled.
    task automatic model_edge();
        logic [N-1:0] evt, clr, n_stable;
        logic [31:0]  rv;
        logic         acc, wr;
        if (!resetn) begin
            s1_m = '0; s2_m = '0; stable_m = '0; stable_prev_m = '0;
            pend_m = '0; en_m = '0; esel_m = '0; irq_m = '0;
            rdata_m = '0; ready_m = 1'b0; rd_m = 1'b0;
            for (int i = 0; i < N; i++) begin
                fill[i] = 0;
                for (int j = 0; j < D; j++) hist[i][j] = 1'b0;
            end
            return;
        end
        for (int i = 0; i < N; i++) begin
            evt[i] = esel_m[i] ? (stable_prev_m[i] && !stable_m[i])
                               : (!stable_prev_m[i] && stable_m[i]);
        end
        acc = sel && mem_valid && !ready_m;
        wr  = (mem_wstrb != 4'd0);
        case (mem_addr[3:2])
            2'd0:    rv = 32'(en_m);
            2'd1:    rv = 32'(pend_m);
            2'd2:    rv = 32'(stable_m);
            default: rv = 32'(esel_m);
        endcase
        clr = '0;
        irq_m = pend_m & en_m;
        if (acc && wr && mem_wstrb[0]) begin
            case (mem_addr[3:2])
                2'd0:    en_m = mem_wdata[N-1:0];
                2'd1:    clr = mem_wdata[N-1:0];
                2'd3:    esel_m = mem_wdata[N-1:0];
                default: ;
            endcase
        end
        pend_m  = (pend_m & ~clr) | evt;
        ready_m = acc;
        rd_m    = acc && !wr;
        rdata_m = (acc && !wr) ? rv : 32'd0;
        // Accept a new level once the last D synchronised samples all disagree with it.
        n_stable = stable_m;
        for (int i = 0; i < N; i++) begin
            bit all_diff;
            for (int j = D - 1; j > 0; j--) hist[i][j] = hist[i][j-1];
            hist[i][0] = s2_m[i];
            if (fill[i] < D) fill[i]++;
            all_diff = (fill[i] == D);
            for (int j = 0; j < D; j++) if (hist[i][j] == stable_m[i]) all_diff = 0;
            if (all_diff) n_stable[i] = !stable_m[i];
        end
        stable_prev_m = stable_m;
        stable_m = n_stable;
        s2_m = s1_m;
        s1_m = irq_in;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic bus_xfer(input string name, input logic [3:0] addr, input logic [3:0] strb,
                            input logic [31:0] wdata, input logic [31:0] exp);
        sel = 1'b1; mem_valid = 1'b1; mem_addr = addr; mem_wstrb = strb; mem_wdata = wdata;
        step();
        chk({name, "_ready"}, 32'(mem_ready), 32'd1);
        if (strb == 4'd0) chk(name, mem_rdata, exp);
        sel = 1'b0; mem_valid = 1'b0; mem_wstrb = 4'd0; mem_wdata = 32'd0;
        step();
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] d);
        bus_xfer("wr", addr, 4'h1, d, 32'd0);
    endtask

    typedef struct {
        logic [3:0]  addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int n;
        tbl[0]  = '{4'h0, 4'h1, 32'hFF,        32'd0};
        tbl[1]  = '{4'h0, 4'h0, 32'd0,         32'd7};
        tbl[2]  = '{4'hC, 4'h1, 32'h5,         32'd0};
        tbl[3]  = '{4'hF, 4'h0, 32'd0,         32'd5};
        tbl[4]  = '{4'h8, 4'h1, 32'h7,         32'd0};
        tbl[5]  = '{4'hA, 4'h0, 32'd0,         32'd0};
        tbl[6]  = '{4'h0, 4'h2, 32'h0,         32'd0};
        tbl[7]  = '{4'h1, 4'h0, 32'd0,         32'd7};
        tbl[8]  = '{4'h0, 4'hF, 32'hFFFF_FFFA, 32'd0};
        tbl[9]  = '{4'h0, 4'h0, 32'd0,         32'd2};
        tbl[10] = '{4'hC, 4'h1, 32'h0,         32'd0};
        tbl[11] = '{4'hC, 4'h0, 32'd0,         32'd0};
        tbl[12] = '{4'h0, 4'h1, 32'h0,         32'd0};

        // Reset with lines high and a request in flight.
        resetn = 1'b0; irq_in = '1; sel = 1'b1; mem_valid = 1'b1;
        mem_addr = 4'h0; mem_wstrb = 4'h0; mem_wdata = 32'd0;
        idle(10);
        chk("rst_irq_out", 32'(irq_out), 32'd0);
        chk("rst_ready", 32'(mem_ready), 32'd0);
        chk("rst_rdata", mem_rdata, 32'd0);
        sel = 1'b0; mem_valid = 1'b0; irq_in = '0; resetn = 1'b1;
        idle(2);
        bus_xfer("rst_enable", 4'h0, 4'h0, 0, 32'd0);
        bus_xfer("rst_pending", 4'h4, 4'h0, 0, 32'd0);
        bus_xfer("rst_level", 4'h8, 4'h0, 0, 32'd0);
        bus_xfer("rst_edgesel", 4'hC, 4'h0, 0, 32'd0);

        // Register access table.
        for (int i = 0; i < 13; i++) begin
            bus_xfer($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].wstrb, tbl[i].wdata, tbl[i].exp);
        end

        // Latency: the edge that first samples the rise is k; irq_out follows 7 edges later.
        wr(4'h0, 32'h1);
        irq_in = 3'b001;
        step();
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (irq_out[0]) begin n = i; break; end
        end
        chk("lat_cycles", n, 7);
        bus_xfer("lat_pending", 4'h4, 4'h0, 0, 32'd1);
        bus_xfer("lat_level", 4'h8, 4'h0, 0, 32'd1);
        irq_in = '0;
        idle(10);
        wr(4'h4, 32'h7);
        step();
        chk("lat_cleared", 32'(irq_out), 32'd0);

        // Glitch rejection on line 1.
        irq_in = 3'b010; idle(3); irq_in = '0; idle(10);
        bus_xfer("glitch_level", 4'h8, 4'h0, 0, 32'd0);
        bus_xfer("glitch_pending", 4'h4, 4'h0, 0, 32'd0);
        irq_in = 3'b010; idle(5); irq_in = '0; idle(12);
        bus_xfer("pulse5_pending", 4'h4, 4'h0, 0, 32'd2);
        wr(4'h4, 32'h7);

        // Masking and clear on line 2.
        wr(4'h0, 32'h0);
        irq_in = 3'b100; idle(12);
        bus_xfer("mask_pending", 4'h4, 4'h0, 0, 32'd4);
        chk("mask_irq_out", 32'(irq_out), 32'd0);
        sel = 1'b1; mem_valid = 1'b1; mem_addr = 4'h0; mem_wstrb = 4'h1; mem_wdata = 32'h4;
        step();
        chk("en_same_cycle", 32'(irq_out), 32'd0);
        sel = 1'b0; mem_valid = 1'b0; mem_wstrb = 4'h0;
        step();
        chk("en_next_cycle", 32'(irq_out), 32'd4);
        wr(4'h4, 32'h4);
        chk("w1c_irq_out", 32'(irq_out), 32'd0);
        irq_in = '0; idle(10);

        // Set/clear collision on line 0: pending sets at edge k+6.
        wr(4'h0, 32'h0);
        irq_in = 3'b001;
        idle(6);
        sel = 1'b1; mem_valid = 1'b1; mem_addr = 4'h4; mem_wstrb = 4'h1; mem_wdata = 32'h1;
        step();
        sel = 1'b0; mem_valid = 1'b0; mem_wstrb = 4'h0;
        step();
        bus_xfer("collide_pending", 4'h4, 4'h0, 0, 32'd1);
        irq_in = '0; idle(10);
        wr(4'h4, 32'h7);

        // Falling mode on line 1.
        wr(4'hC, 32'h2);
        wr(4'h0, 32'h2);
        irq_in = 3'b010; idle(12);
        bus_xfer("fall_rise_pending", 4'h4, 4'h0, 0, 32'd0);
        chk("fall_rise_irq", 32'(irq_out), 32'd0);
        irq_in = '0;
        step();
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (irq_out[1]) begin n = i; break; end
        end
        chk("fall_cycles", n, 7);
        bus_xfer("fall_pending", 4'h4, 4'h0, 0, 32'd2);

        // Random phase against the reference model, with occasional resets.
        resetn = 1'b0; idle(2); resetn = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(0, 5) == 0) irq_in[i] = !irq_in[i];
            sel       = ($urandom_range(0, 3) != 0);
            mem_valid = ($urandom_range(0, 1) != 0);
            mem_addr  = 4'($urandom);
            mem_wstrb = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom);
            mem_wdata = $urandom;
            resetn    = ($urandom_range(0, 299) != 0);
            step();
            chk("rnd_irq_out", 32'(irq_out), 32'(irq_m));
            chk("rnd_ready", 32'(mem_ready), 32'(ready_m));
            if (!ready_m || rd_m) chk("rnd_rdata", mem_rdata, rdata_m);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
